// File: rtl/aes_kat_bist.sv
`default_nettype none
// ============================================================================
// Module   : aes_kat_bist
// Purpose  : Known-answer self-test sequencer for an AES-128 core. On start it
//            streams NUM_VEC ROM vectors into the core at one per clock. Each
//            result is compared with the ROM's expected ciphertext exactly
//            LATENCY cycles after that vector was placed on the core inputs,
//            and a pass/fail summary is held until the next run.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start              - run request (accepted in IDLE/DONE only)
//            vec_idx            - ROM address; vec_state/vec_key/vec_expect
//                                 are the ROM data returned in the same cycle
//            core_state/core_key- registered stimulus to the core
//            core_out           - core ciphertext
//            busy, done, pass   - run status; pass is qualified by done
//            fail_cnt           - number of mismatching vectors
//            first_fail_idx     - index of first mismatch, all-ones if none
// Options  : AES_KAT_LEAK_MON_EN - adds antena input and leak_cnt output; any
//            rising edge on antena during a run makes the run fail.
// Revision : 1.0 - initial release
// ============================================================================
module aes_kat_bist #(
    parameter int DATA_W  = 128,
    parameter int NUM_VEC = 5,
    parameter int LATENCY = 21,
    parameter int IDX_W   = $clog2(NUM_VEC + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IDX_W-1:0]  vec_idx,
    input  logic [DATA_W-1:0] vec_state,
    input  logic [DATA_W-1:0] vec_key,
    input  logic [DATA_W-1:0] vec_expect,
    output logic [DATA_W-1:0] core_state,
    output logic [DATA_W-1:0] core_key,
    input  logic [DATA_W-1:0] core_out,
`ifdef AES_KAT_LEAK_MON_EN
    input  logic              antena,
    output logic [15:0]       leak_cnt,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W-1:0]  fail_cnt,
    output logic [IDX_W-1:0]  first_fail_idx
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              w_busy;
    logic              w_done;
    logic              w_start_acc;
    logic              w_issue;

    logic [IDX_W-1:0]  r_issue_cnt;
    logic [DATA_W-1:0] r_core_state;
    logic [DATA_W-1:0] r_core_key;
    logic [IDX_W-1:0]  r_fail_cnt;
    logic [IDX_W-1:0]  r_first_fail;
    logic              r_last_chk;

    // Expectation delay line. An entry enters stage 0 on the same edge its
    // vector is loaded onto core_state, so stage LATENCY holds the entry
    // whose core result is on core_out in the current cycle.
    logic [LATENCY:0]  r_dl_vld;
    logic [IDX_W-1:0]  r_dl_idx [0:LATENCY];
    logic [DATA_W-1:0] r_dl_exp [0:LATENCY];

    logic              w_tail_vld;
    logic              w_mismatch;
    logic              w_tail_last;

    assign w_issue     = (r_state == S_ISSUE);
    assign w_tail_vld  = r_dl_vld[LATENCY];
    assign w_mismatch  = w_tail_vld && (core_out != r_dl_exp[LATENCY]);
    assign w_tail_last = w_tail_vld && (r_dl_idx[LATENCY] == c_last_idx);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_busy = 1'b1;
                if (r_issue_cnt == c_last_idx) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                // r_last_chk rises on the edge that scores the final vector,
                // so DONE follows one cycle after the last comparison.
                if (r_last_chk) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue, check and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt  <= '0;
            r_core_state <= '0;
            r_core_key   <= '0;
            r_dl_vld     <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '1;
            r_last_chk   <= 1'b0;
        end else begin
            // Core inputs are zero whenever no vector is being issued.
            r_core_state <= w_issue ? vec_state : '0;
            r_core_key   <= w_issue ? vec_key   : '0;

            if (w_start_acc) begin
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + IDX_W'(1);
            end

            if (w_start_acc) begin
                r_dl_vld <= '0;
            end else begin
                r_dl_vld <= {r_dl_vld[LATENCY-1:0], w_issue};
            end

            if (w_start_acc) begin
                r_fail_cnt   <= '0;
                r_first_fail <= '1;
                r_last_chk   <= 1'b0;
            end else begin
                if (w_mismatch) begin
                    r_fail_cnt <= r_fail_cnt + IDX_W'(1);
                    if (r_fail_cnt == '0) begin
                        r_first_fail <= r_dl_idx[LATENCY];
                    end
                end
                if (w_tail_last) begin
                    r_last_chk <= 1'b1;
                end
            end
        end
    end

    // Payload of the delay line needs no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        r_dl_idx[0] <= r_issue_cnt;
        r_dl_exp[0] <= vec_expect;
        for (int j = 1; j <= LATENCY; j++) begin
            r_dl_idx[j] <= r_dl_idx[j-1];
            r_dl_exp[j] <= r_dl_exp[j-1];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vec_idx        = w_issue ? r_issue_cnt : '0;
    assign core_state     = r_core_state;
    assign core_key       = r_core_key;
    assign busy           = w_busy;
    assign done           = w_done;
    assign fail_cnt       = r_fail_cnt;
    assign first_fail_idx = r_first_fail;

`ifdef AES_KAT_LEAK_MON_EN
    logic        r_antena_q;
    logic [15:0] r_leak_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_antena_q <= 1'b0;
            r_leak_cnt <= '0;
        end else begin
            r_antena_q <= antena;
            if (w_start_acc) begin
                r_leak_cnt <= '0;
            end else if (w_busy && antena && !r_antena_q &&
                         (r_leak_cnt != 16'hFFFF)) begin
                r_leak_cnt <= r_leak_cnt + 16'd1;
            end
        end
    end

    assign leak_cnt = r_leak_cnt;
    assign pass     = w_done && (r_fail_cnt == '0) && (r_leak_cnt == 16'd0);
`else
    assign pass     = w_done && (r_fail_cnt == '0);
`endif

endmodule

`default_nettype wire

// File: doc/aes_kat_bist.md
# aes_kat_bist

Parametrised built-in self-test sequencer for the AES-128 core (`top`). On `start`, it streams NUM_VEC known-answer vectors into the core at one vector per clock. It then compares each core result against the expected ciphertext exactly LATENCY cycles later and reports a pass/fail summary. It sits between the vector ROM and the core, in place of a hand-written stimulus/check bench, so KAT can run in silicon and in simulation.

## Interface
Parameters:
- `DATA_W`, 128: width of state, key and ciphertext.
- `NUM_VEC`, 5: number of vectors per run; legal range 1..255.
- `LATENCY`, 21: cycles from the vector being on `core_state`/`core_key` to its result on `core_out`; legal range 1..64.
- `IDX_W`, `$clog2(NUM_VEC+1)`: width of the index and counter fields.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle run request; ignored unless the FSM is in IDLE or DONE.
- `vec_idx` output IDX_W: index of the vector currently requested from the ROM.
- `vec_state` input DATA_W: plaintext for `vec_idx`; combinational ROM data, same cycle.
- `vec_key` input DATA_W: key for `vec_idx`.
- `vec_expect` input DATA_W: expected ciphertext for `vec_idx`.
- `core_state` output DATA_W: registered plaintext to the core.
- `core_key` output DATA_W: registered key to the core.
- `core_out` input DATA_W: core ciphertext.
- `busy` output 1: high in ISSUE and DRAIN.
- `done` output 1: high in DONE.
- `pass` output 1: valid when `done` is high; 1 means zero mismatches.
- `fail_cnt` output IDX_W: number of mismatching vectors.
- `first_fail_idx` output IDX_W: index of the first mismatch; all-ones if there was none.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE or DONE, with `start`=1:
  - go to ISSUE;
  - clear `fail_cnt` and set `first_fail_idx` to all-ones;
  - clear the issue counter `i`.
- ISSUE:
  - `vec_idx`=`i`.
  - On each edge, `core_state`/`core_key` load `vec_state`/`vec_key`.
  - `{valid=1, idx=i, vec_expect}` enters an expectation delay line.
  - `i` increments.
  - After the edge that issues `i`=NUM_VEC-1, go to DRAIN.
- DRAIN:
  - `core_state`/`core_key` load 0.
  - Invalid entries enter the delay line.
  - Go to DONE once the last valid entry has been checked.
- Check rule: the entry issued onto the core inputs in cycle t is compared with `core_out` in cycle t+LATENCY. Full DATA_W equality is required.
  - On a mismatch, `fail_cnt` increments.
  - On the first mismatch of a run, `first_fail_idx` captures that entry's `idx`.
- DONE:
  - `pass` = (`fail_cnt`==0).
  - Results hold until the next accepted `start` or `rst`.
- `start` in ISSUE or DRAIN is ignored.
- `vec_idx` is 0 outside ISSUE.

## Timing
- Reset values:
  - FSM = IDLE;
  - `core_state`, `core_key`, `vec_idx`, `fail_cnt` = 0;
  - `first_fail_idx` = all-ones;
  - `busy`, `done`, `pass` = 0;
  - delay line all invalid.
- `start` sampled at edge e0 → `busy`=1 from e0; vector 0 is on `core_state` after edge e0+1.
- Vector k is checked at edge e0+1+k+LATENCY.
- `done` rises at edge e0+NUM_VEC+LATENCY+2; total run length is NUM_VEC+LATENCY+2 cycles.
- `rst` mid-run aborts immediately to reset values. Checks in flight are discarded and no partial results are held.
- `fail_cnt` never overflows: IDX_W holds NUM_VEC.
- A restart from DONE clears the previous results at the accepting edge.

## Configuration
- Macro: `AES_KAT_LEAK_MON_EN`.
- Defined:
  - adds input `antena` (1 bit) and output `leak_cnt` (16 bits, reset 0, cleared on accepted `start`);
  - `leak_cnt` counts rising edges of `antena` sampled while `busy`=1, saturating at 16'hFFFF;
  - `pass` = (`fail_cnt`==0) && (`leak_cnt`==0). A core leaking through its antenna pin therefore fails KAT.
- Undefined: neither port exists, there is no edge-detect logic, and `pass` depends on mismatches only.

## Test plan
- FIPS-197 pass: ROM holds {3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, expect 3925841d02dc09fbdc118597196a0b32} plus the four other standard vectors, with a correct core model → `done` at e0+28, `pass`=1, `fail_cnt`=0, `first_fail_idx`=7.
- Corrupted expectation: vector 2's expect is changed to 66e94bd4ef8a2c3b884cfa59ca342b2f → `pass`=0, `fail_cnt`=1, `first_fail_idx`=2.
- Latency mismatch: core model delays results by 22 against LATENCY=21 → `fail_cnt`=5, `first_fail_idx`=0.
- Abort and restart:
  - `rst` asserted 10 cycles into ISSUE/DRAIN → all outputs return to reset values the next cycle;
  - a fresh `start` then reproduces the pass result;
  - `start` pulsed mid-run without reset → no effect on timing or counts.
- Leak monitor, macro defined: `antena` toggles 3 rising edges during the run, all vectors correct → `leak_cnt`=3, `pass`=0; with `antena` held 0 → `pass`=1.
